compute_sequencer: RTL and testbench
====================================

COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter ARR_SIZE, default 4: PE rows/columns of the MAC array.
REQ-002 Parameter ADDR_W, default 7: banked-buffer address width.
REQ-003 Parameter LEN_W, default 7: width of the MATMUL depth field.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  sequencer accepts the command this cycle.
REQ-008 cmd_op  in  2  command: 00 WR_INP, 01 WR_WT, 10 MATMUL, 11 CLEAR.
REQ-009 cmd_addr  in  ADDR_W  write address (WR_*) or start read address (MATMUL).
REQ-010 cmd_data  in  32  write data (WR_*).
REQ-011 cmd_len  in  LEN_W  MATMUL depth K (operand vectors to stream).
REQ-012 buf_state  out  2  banked-buffer mode: 00 IDLE, 01 WRITE, 10 READ.
REQ-013 inp_buf_addr / wt_buf_addr  out  ADDR_W each  buffer addresses.
REQ-014 inp_buf_data / wt_buf_data  out  32 each  buffer write data.
REQ-015 i_mode  out  1  MAC enable, high only while operands stream or drain.
REQ-016 acc_reset  out  1  one-cycle accumulator clear.
REQ-017 store_output  out  1  accumulator-to-output-buffer store strobe.
REQ-018 acc_op_addr  out  $clog2(ARR_SIZE*ARR_SIZE)  accumulator/output-buffer entry index.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse when MATMUL or CLEAR completes.

Function
REQ-021 Handshake: command accepted iff cmd_valid && cmd_ready; cmd_ready = (state == IDLE).
REQ-022 FSM states: IDLE, WRITE, CLEAR, COMPUTE, DRAIN, STORE, DONE.
REQ-023 WR_INP/WR_WT: IDLE -> WRITE for exactly 1 cycle.
  - buf_state = 01; registered cmd_addr/cmd_data on the selected buffer's addr/data.
  - Unselected buffer: addr and data held at 0.
  - Return to IDLE; no done pulse.
REQ-024 CLEAR: IDLE -> CLEAR (acc_reset = 1, 1 cycle) -> DONE -> IDLE.
REQ-025 MATMUL with cmd_len = 0: treated as CLEAR (same sequence, same outputs).
REQ-026 MATMUL with cmd_len = K > 0: IDLE -> COMPUTE.
  - acc_reset = 1 in the first COMPUTE cycle only.
  - Lasts K cycles; buf_state = 10, i_mode = 1.
  - Both buffer addresses = cmd_addr + n, n = 0..K-1, wrapping modulo 2^ADDR_W.
REQ-027 DRAIN: 2*ARR_SIZE-1 cycles (skew flush); i_mode = 1, buf_state = 00, addresses held at last value.
REQ-028 STORE: ARR_SIZE*ARR_SIZE cycles; store_output = 1, acc_op_addr = 0..ARR_SIZE^2-1 ascending, i_mode = 0.
REQ-029 DONE: done = 1 for 1 cycle, then IDLE.
REQ-030 Latency: MATMUL accept to done = K + 2*ARR_SIZE-1 + ARR_SIZE^2 + 1 cycles.
REQ-031 Default outside the states named above: acc_reset, store_output, i_mode, done = 0; buf_state = 00.
REQ-032 Counters: saturate at no value, reset to 0 on every state entry.
REQ-033 cmd_* changes after acceptance do not affect the running command.
REQ-034 cmd_valid while busy: command not accepted, state unaffected.

Reset
REQ-035 rst low (asynchronous, any state, including mid-MATMUL): FSM = IDLE, counters = 0.
REQ-036 Outputs during reset: cmd_ready = 1; every other output = 0 (buf_state = 00, addresses/data 0).
REQ-037 rst release: first command accepted on the first rising edge with rst high.

Structure
REQ-038 Shared package: cmd_op encodings, buf_state encodings, FSM state enum, ARR_SIZE default.
REQ-039 Single module; the address/step counter is inline, with no sub-module.

Verification
REQ-040 WR_WT addr 5, data 0xDEADBEEF -> 1 cycle with buf_state = 01, wt_buf_addr = 5, wt_buf_data = 0xDEADBEEF, inp_buf_* = 0; no done.
REQ-041 MATMUL addr 0, len 4 (ARR_SIZE 4) -> acc_reset 1 cycle; 4 COMPUTE cycles with addresses 0..3; 7 DRAIN; 16 store_output cycles with acc_op_addr 0..15; done at cycle 28 after accept.
REQ-042 MATMUL addr 126, len 4 -> read addresses 126, 127, 0, 1.
REQ-043 MATMUL len 0 and CLEAR -> acc_reset 1 cycle, done 2 cycles after accept, i_mode never high.
REQ-044 cmd_valid held during MATMUL -> cmd_ready = 0 throughout; next command accepted the cycle after done.
REQ-045 rst low during STORE (acc_op_addr = 9) -> outputs 0 immediately, cmd_ready = 1; no done pulse.

Source files
------------

// File: rtl/compute_sequencer_pkg.sv
// compute_sequencer_pkg
//   Shared encodings for the compute sequencer: command opcodes, banked-buffer
//   mode codes, the sequencer FSM state enum and the default MAC array size.
package compute_sequencer_pkg;

  localparam int ARR_SIZE_DEF = 4;

  // cmd_op encodings
  localparam logic [1:0] OP_WR_INP = 2'b00;
  localparam logic [1:0] OP_WR_WT  = 2'b01;
  localparam logic [1:0] OP_MATMUL = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // buf_state encodings
  localparam logic [1:0] BUF_IDLE  = 2'b00;
  localparam logic [1:0] BUF_WRITE = 2'b01;
  localparam logic [1:0] BUF_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_STORE   = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/compute_sequencer.sv
// compute_sequencer
//   Command sequencer for a systolic MAC array. Accepts buffer writes, MATMUL
//   and CLEAR commands, then walks the array through compute (operand
//   streaming), drain (skew flush) and store (accumulator readout) phases.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op/addr/data/len command fields
//   buf_state           banked-buffer mode (IDLE/WRITE/READ)
//   inp_buf_*/wt_buf_*  input and weight buffer address/write data
//   i_mode              MAC enable (compute and drain)
//   acc_reset           one-cycle accumulator clear
//   store_output        accumulator-to-output-buffer strobe
//   acc_op_addr         accumulator entry index during store
//   busy, done          activity flag, completion pulse
//   dbg_state           current FSM state for observation
module compute_sequencer
  import compute_sequencer_pkg::*;
#(
  parameter int ARR_SIZE = ARR_SIZE_DEF,
  parameter int ADDR_W   = 7,
  parameter int LEN_W    = 7,
  localparam int ACC_W   = (ARR_SIZE > 1) ? $clog2(ARR_SIZE * ARR_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [1:0]        buf_state,
  output logic [ADDR_W-1:0] inp_buf_addr,
  output logic [ADDR_W-1:0] wt_buf_addr,
  output logic [31:0]       inp_buf_data,
  output logic [31:0]       wt_buf_data,
  output logic              i_mode,
  output logic              acc_reset,
  output logic              store_output,
  output logic [ACC_W-1:0]  acc_op_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // One counter serves every timed phase, so it must hold the largest of
  // K-1, 2*ARR_SIZE-2 and ARR_SIZE^2-1.
  localparam int CNT_W = ((LEN_W > ACC_W) ? LEN_W : ACC_W) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * ARR_SIZE - 2);
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(ARR_SIZE * ARR_SIZE - 1);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_sel_wt;
  logic [LEN_W-1:0]  r_len;
  logic              w_accept;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign dbg_state = r_state;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, so commands
  // offered while busy simply wait and never disturb the running one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_sel_wt <= 1'b0;
      r_len    <= '0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state change and idles at zero.
      if (w_next != r_state || r_state == ST_IDLE) r_cnt <= '0;
      else                                         r_cnt <= w_cnt_inc;
      if (w_accept) begin
        r_addr   <= cmd_addr;
        r_data   <= cmd_data;
        r_sel_wt <= (cmd_op == OP_WR_WT);
        r_len    <= cmd_len;
      end else if (r_state == ST_COMPUTE && w_next == ST_COMPUTE) begin
        // Step the read address; on the final compute cycle it is left at
        // the last address so drain presents it unchanged.
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    cmd_ready    = (r_state == ST_IDLE);
    busy         = (r_state != ST_IDLE);
    buf_state    = BUF_IDLE;
    inp_buf_addr = '0;
    wt_buf_addr  = '0;
    inp_buf_data = '0;
    wt_buf_data  = '0;
    i_mode       = 1'b0;
    acc_reset    = 1'b0;
    store_output = 1'b0;
    acc_op_addr  = '0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          case (cmd_op)
            OP_WR_INP, OP_WR_WT: w_next = ST_WRITE;
            // A zero-depth MATMUL has nothing to stream: behave as CLEAR.
            OP_MATMUL: w_next = (cmd_len == '0) ? ST_CLEAR : ST_COMPUTE;
            default:   w_next = ST_CLEAR;
          endcase
        end
      end
      ST_WRITE: begin
        buf_state = BUF_WRITE;
        if (r_sel_wt) begin
          wt_buf_addr = r_addr;
          wt_buf_data = r_data;
        end else begin
          inp_buf_addr = r_addr;
          inp_buf_data = r_data;
        end
        w_next = ST_IDLE;
      end
      ST_CLEAR: begin
        acc_reset = 1'b1;
        w_next    = ST_DONE;
      end
      ST_COMPUTE: begin
        buf_state    = BUF_READ;
        i_mode       = 1'b1;
        inp_buf_addr = r_addr;
        wt_buf_addr  = r_addr;
        acc_reset    = (r_cnt == '0);
        if (w_cnt_inc == CNT_W'(r_len)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        i_mode       = 1'b1;
        inp_buf_addr = r_addr;
        wt_buf_addr  = r_addr;
        if (r_cnt == DRAIN_LAST) w_next = ST_STORE;
      end
      ST_STORE: begin
        store_output = 1'b1;
        acc_op_addr  = r_cnt[ACC_W-1:0];
        if (r_cnt == STORE_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_compute_sequencer.sv
// tb_compute_sequencer
//   Randomized bench for compute_sequencer. A behavioural model turns each
//   command into the cycle-by-cycle output trace it should produce; scenario
//   tasks drive commands and compare the DUT against that trace.
module tb_compute_sequencer;
  import compute_sequencer_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 7;
  localparam int LW    = 7;
  localparam int ACC_W = 4;
  localparam int VW    = 90;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op    = '0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [31:0]   cmd_data  = '0;
  logic [LW-1:0] cmd_len   = '0;
  logic [1:0]    buf_state;
  logic [AW-1:0] inp_buf_addr, wt_buf_addr;
  logic [31:0]   inp_buf_data, wt_buf_data;
  logic          i_mode, acc_reset, store_output, busy, done;
  logic [ACC_W-1:0] acc_op_addr;
  logic [2:0]    dbg_state;

  compute_sequencer #(.ARR_SIZE(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .buf_state(buf_state),
    .inp_buf_addr(inp_buf_addr), .wt_buf_addr(wt_buf_addr),
    .inp_buf_data(inp_buf_data), .wt_buf_data(wt_buf_data),
    .i_mode(i_mode), .acc_reset(acc_reset), .store_output(store_output),
    .acc_op_addr(acc_op_addr), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  function automatic logic [VW-1:0] vec(
    input logic rdy, input logic bsy, input logic dn, input logic [1:0] bs,
    input logic [AW-1:0] ia, input logic [AW-1:0] wa,
    input logic [31:0] id, input logic [31:0] wd,
    input logic im, input logic ar, input logic so, input logic [ACC_W-1:0] aa);
    return {rdy, bsy, dn, bs, ia, wa, id, wd, im, ar, so, aa};
  endfunction

  function automatic logic [VW-1:0] obs();
    return vec(cmd_ready, busy, done, buf_state, inp_buf_addr, wt_buf_addr,
               inp_buf_data, wt_buf_data, i_mode, acc_reset, store_output, acc_op_addr);
  endfunction

  function automatic logic [VW-1:0] idle_vec();
    return vec(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  // Reference model: expected outputs for every cycle after acceptance,
  // ending with the first IDLE cycle.
  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [31:0] data, input int len);
    logic [AW-1:0] a;
    if (op == OP_WR_INP) begin
      exp_q.push_back(vec(0, 1, 0, 2'b01, addr, '0, data, '0, 0, 0, 0, '0));
    end else if (op == OP_WR_WT) begin
      exp_q.push_back(vec(0, 1, 0, 2'b01, '0, addr, '0, data, 0, 0, 0, '0));
    end else if (op == OP_CLEAR || len == 0) begin
      exp_q.push_back(vec(0, 1, 0, 2'b00, '0, '0, '0, '0, 0, 1, 0, '0));
      exp_q.push_back(vec(0, 1, 1, 2'b00, '0, '0, '0, '0, 0, 0, 0, '0));
    end else begin
      for (int t = 0; t < len; t++) begin
        a = AW'(int'(addr) + t);
        exp_q.push_back(vec(0, 1, 0, 2'b10, a, a, '0, '0, 1, (t == 0), 0, '0));
      end
      a = AW'(int'(addr) + len - 1);
      for (int d = 0; d < 2 * N - 1; d++)
        exp_q.push_back(vec(0, 1, 0, 2'b00, a, a, '0, '0, 1, 0, 0, '0));
      for (int s = 0; s < N * N; s++)
        exp_q.push_back(vec(0, 1, 0, 2'b00, '0, '0, '0, '0, 0, 0, 1, ACC_W'(s)));
      exp_q.push_back(vec(0, 1, 1, 2'b00, '0, '0, '0, '0, 0, 0, 0, '0));
    end
    exp_q.push_back(idle_vec());
  endtask

  // driver: offer a command for one edge, then scramble the fields
  task automatic drive_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [LW-1:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_len = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_data  = $urandom;
    cmd_len   = LW'($urandom);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== idle_vec()) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", obs(), idle_vec());
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MATMUL; cmd_len = 7'd5;
    @(negedge clk);
    checks++;
    if (obs() !== idle_vec()) begin
      errors++; $display("FAIL reset_hold got %h exp %h", obs(), idle_vec());
    end
    // release and offer a write in the same cycle: first edge must take it
    d = $urandom;
    rst = 1'b1; cmd_op = OP_WR_INP; cmd_addr = 7'd33; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    model_cmd(OP_WR_INP, 7'd33, d, 0);
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL reset_release cyc %0d got %h exp %h", n, obs(), e);
      end
    end
  endtask

  task automatic test_write();
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [31:0] d;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        op = OP_WR_WT; a = 7'd5; d = 32'hDEADBEEF;
      end else begin
        op = ($urandom_range(0, 1) == 0) ? OP_WR_INP : OP_WR_WT;
        a = AW'($urandom); d = $urandom;
      end
      drive_cmd(op, a, d, LW'($urandom));
      model_cmd(op, a, d, 0);
      for (int n = 0; exp_q.size() > 0; n++) begin
        logic [VW-1:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL write%0d cyc %0d got %h exp %h", i, n, obs(), e);
        end
      end
    end
  endtask

  task automatic test_matmul();
    logic [AW-1:0] a;
    int k;
    int done_cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        a = '0; k = 4;
      end else begin
        a = AW'($urandom); k = $urandom_range(1, 12);
      end
      done_cyc = -1;
      drive_cmd(OP_MATMUL, a, $urandom, LW'(k));
      model_cmd(OP_MATMUL, a, '0, k);
      for (int n = 0; exp_q.size() > 0; n++) begin
        logic [VW-1:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        if (done === 1'b1 && done_cyc < 0) done_cyc = n + 1;
        checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL matmul%0d cyc %0d got %h exp %h", i, n, obs(), e);
        end
      end
      checks++;
      if (done_cyc != k + 2 * N - 1 + N * N + 1) begin
        errors++;
        $display("FAIL matmul%0d_latency got %0d exp %0d", i, done_cyc, k + 2 * N - 1 + N * N + 1);
      end
    end
  endtask

  task automatic test_wrap();
    drive_cmd(OP_MATMUL, 7'd126, '0, 7'd4);
    model_cmd(OP_MATMUL, 7'd126, '0, 4);
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL wrap cyc %0d got %h exp %h", n, obs(), e);
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] op;
      op = (i % 2 == 0) ? OP_CLEAR : OP_MATMUL;
      drive_cmd(op, AW'($urandom), $urandom, (op == OP_MATMUL) ? '0 : LW'($urandom));
      model_cmd(op, '0, '0, 0);
      for (int n = 0; exp_q.size() > 0; n++) begin
        logic [VW-1:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL clear%0d cyc %0d got %h exp %h", i, n, obs(), e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int idle_idx;
    logic [31:0] d;
    k = $urandom_range(1, 6);
    d = $urandom;
    idle_idx = k + 2 * N - 1 + N * N + 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MATMUL; cmd_addr = 7'd20; cmd_len = LW'(k);
    @(posedge clk);
    // keep offering a different command for the whole MATMUL
    #1 cmd_op = OP_WR_WT; cmd_addr = 7'd99; cmd_data = d; cmd_len = 7'd3;
    model_cmd(OP_MATMUL, 7'd20, '0, k);
    model_cmd(OP_WR_WT, 7'd99, d, 0);
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL b2b cyc %0d got %h exp %h", n, obs(), e);
      end
      if (n == idle_idx) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int stop;
    logic [31:0] d;
    drive_cmd(OP_MATMUL, 7'd10, '0, 7'd3);
    model_cmd(OP_MATMUL, 7'd10, '0, 3);
    stop = 3 + 2 * N - 1 + 10;  // through the cycle with acc_op_addr = 9
    for (int n = 0; n < stop; n++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL mid_store cyc %0d got %h exp %h", n, obs(), e);
      end
    end
    exp_q.delete();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== idle_vec()) begin
      errors++; $display("FAIL mid_store_reset got %h exp %h", obs(), idle_vec());
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (obs() !== idle_vec()) begin
        errors++; $display("FAIL mid_store_hold cyc %0d got %h exp %h", n, obs(), idle_vec());
      end
    end
    rst = 1'b1;
    d = $urandom;
    drive_cmd(OP_WR_INP, 7'd7, d, '0);
    model_cmd(OP_WR_INP, 7'd7, d, 0);
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL post_reset cyc %0d got %h exp %h", n, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_matmul();
    test_wrap();
    test_clear();
    test_back_to_back();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
